// File: rtl/mem_line_requester_pkg.sv
// rtl/mem_line_requester_pkg.sv - shared widths, state encoding and line word-slice helper
package mem_line_requester_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;
    localparam int SEL_BITS   = 2;
    localparam int TAG_BITS   = WORD_SIZE - SEL_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Word k of a line lives at bits [16k+15:16k].
    function automatic logic [WORD_SIZE-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [SEL_BITS-1:0]  sel
    );
        return line[int'(sel) * WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/mem_line_requester_if.sv
// rtl/mem_line_requester_if.sv - strobe/done bus between requester and delayed line memory
interface mem_line_requester_if;
    import mem_line_requester_pkg::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_done;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_done
    );

endinterface

// File: rtl/mem_line_requester_line_buffer.sv
// rtl/mem_line_requester_line_buffer.sv - single-entry line buffer with fill, word update and lookup
module mem_line_requester_line_buffer
    import mem_line_requester_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 invalidate,
    input  logic                 fill,
    input  logic [TAG_BITS-1:0]  fill_tag,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 word_write,
    input  logic [SEL_BITS-1:0]  write_sel,
    input  logic [WORD_SIZE-1:0] write_word,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    input  logic [SEL_BITS-1:0]  read_sel,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] read_word
);

    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [LINE_BITS-1:0] data;

    // Disabled buffer never hits, so every read and write goes to memory.
    assign hit       = ENABLE && valid && (tag == lookup_tag);
    assign read_word = line_word(data, read_sel);

    // Entry update: invalidate wins, then a full-line fill, then a single-word write-through.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_line;
        end else if (word_write) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                if (write_sel == SEL_BITS'(k)) begin
                    data[k*WORD_SIZE +: WORD_SIZE] <= write_word;
                end
            end
        end
    end

endmodule

// File: rtl/mem_line_requester.sv
// rtl/mem_line_requester.sv - CPU-side word requester for the delayed line memory
module mem_line_requester
    import mem_line_requester_pkg::*;
#(
    parameter int TIMEOUT    = 31,
    parameter bit LINEBUF_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [WORD_SIZE-1:0]    cpu_addr,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_rvalid,
    output logic [WORD_SIZE-1:0]    cpu_rdata,
    output logic                    cpu_wdone,
    mem_line_requester_if.master    mem,
    output logic                    err_timeout
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 accept;
    logic                 in_wait;
    logic                 expired;
    logic                 enter_wait;
    logic                 fill;
    logic                 invalidate;
    logic                 word_write;
    logic                 buf_hit;
    logic [WORD_SIZE-1:0] buf_word;

    assign cpu_ready  = (state == IDLE);
    assign cpu_rvalid = (state == RESP);
    assign accept     = cpu_req & cpu_ready;
    assign in_wait    = (state == RD_WAIT) || (state == WR_WAIT);
    // The last wait cycle without done is the TIMEOUT-th one spent in the wait state.
    assign expired    = in_wait & ~mem.mem_done & (wait_cnt == CNT_LAST);
    assign word_write = accept & cpu_we & buf_hit;

    // Strobes are combinational so they fall in the very cycle done is seen.
    assign mem.mem_read  = (state == RD_WAIT) & ~mem.mem_done;
    assign mem.mem_write = (state == WR_WAIT) & ~mem.mem_done;

    mem_line_requester_line_buffer #(
        .ENABLE (LINEBUF_EN)
    ) u_line_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .invalidate (invalidate),
        .fill       (fill),
        .fill_tag   (mem.mem_addr[WORD_SIZE-1:SEL_BITS]),
        .fill_line  (mem.mem_rdata),
        .word_write (word_write),
        .write_sel  (cpu_addr[SEL_BITS-1:0]),
        .write_word (cpu_wdata),
        .lookup_tag (cpu_addr[WORD_SIZE-1:SEL_BITS]),
        .read_sel   (cpu_addr[SEL_BITS-1:0]),
        .hit        (buf_hit),
        .read_word  (buf_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus buffer fill/invalidate requests.
    always_comb begin
        state_nxt  = state;
        enter_wait = 1'b0;
        fill       = 1'b0;
        invalidate = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cpu_we) begin
                        state_nxt  = WR_WAIT;
                        enter_wait = 1'b1;
                    end else if (buf_hit) begin
                        state_nxt  = RESP;
                    end else begin
                        state_nxt  = RD_WAIT;
                        enter_wait = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (mem.mem_done) begin
                    state_nxt = RESP;
                    fill      = 1'b1;
                end else if (expired) begin
                    state_nxt  = IDLE;
                    invalidate = 1'b1;
                end
            end
            WR_WAIT: begin
                if (mem.mem_done || expired) begin
                    state_nxt  = IDLE;
                    invalidate = expired;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latches, wait counter, read data, write acknowledge and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            wait_cnt      <= '0;
            cpu_rdata     <= '0;
            cpu_wdone     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            cpu_wdone <= (state == WR_WAIT) & mem.mem_done;
            if (expired) begin
                err_timeout <= 1'b1;
            end
            if (enter_wait) begin
                mem.mem_addr <= cpu_addr;
                wait_cnt     <= '0;
                if (cpu_we) begin
                    mem.mem_wdata <= cpu_wdata;
                end
            end else if (in_wait && !mem.mem_done && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept && !cpu_we && buf_hit) begin
                cpu_rdata <= buf_word;
            end else if (state == RD_WAIT && mem.mem_done) begin
                cpu_rdata <= line_word(mem.mem_rdata, mem.mem_addr[SEL_BITS-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_mem_line_requester.sv
// tb/tb_mem_line_requester.sv - directed self-checking bench for mem_line_requester
module tb_mem_line_requester;
    import mem_line_requester_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        cpu_wdone;
    logic        err_timeout;

    mem_line_requester_if mem_bus ();

    mem_line_requester #(
        .TIMEOUT    (31),
        .LINEBUF_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .cpu_wdone   (cpu_wdone),
        .mem         (mem_bus),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: delay 6, done one cycle after the 7th strobed edge.
    bit          mem_block = 1'b0;
    bit          inj_done  = 1'b0;
    bit          model_done = 1'b0;
    int unsigned m_cnt = 0;
    int          rd_txn = 0;
    bit          wr_flag [0:65535];
    bit   [15:0] wr_data [0:65535];
    logic [63:0] model_rdata;
    logic [15:0] idx;

    function automatic logic [15:0] default_word(input logic [15:0] a);
        case (a)
            16'h0021: return 16'h0000;
            16'h0023: return 16'h6000;
            16'h0024: return 16'hF01C;
            16'h0028: return 16'hF81C;
            default:  return {4'hA, a[11:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_block && (mem_bus.mem_read || mem_bus.mem_write) && !model_done) begin
            if (m_cnt == 6) begin
                model_done <= 1'b1;
                m_cnt      <= 0;
                if (mem_bus.mem_write) begin
                    wr_flag[mem_bus.mem_addr] <= 1'b1;
                    wr_data[mem_bus.mem_addr] <= mem_bus.mem_wdata;
                end else begin
                    rd_txn <= rd_txn + 1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            model_done <= 1'b0;
            m_cnt      <= 0;
        end
    end

    always_comb begin
        model_rdata = '0;
        idx         = '0;
        for (int k = 0; k < 4; k++) begin
            idx = {mem_bus.mem_addr[15:2], 2'(k)};
            model_rdata[k*16 +: 16] = wr_flag[idx] ? wr_data[idx] : default_word(idx);
        end
    end

    assign mem_bus.mem_rdata = model_rdata;
    assign mem_bus.mem_done  = model_done | inj_done;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a read; index i counts cycles after the accepting edge (edge 0).
    task automatic do_read(input logic [15:0] a, input int max_cyc,
                           output int rd_high, output int rv_at, output int err_at,
                           output logic [15:0] data);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        rd_high  = 0;
        rv_at    = -1;
        err_at   = -1;
        data     = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (mem_bus.mem_read) rd_high++;
            if (mem_bus.mem_read && mem_bus.mem_done) overlap++;
            if (err_timeout && err_at < 0) err_at = i;
            if (cpu_rvalid) begin
                rv_at = i;
                data  = cpu_rdata;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int max_cyc,
                            output int wr_high, output int wd_at,
                            output logic [15:0] lat_addr, output logic [15:0] lat_data);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        wr_high   = 0;
        wd_at     = -1;
        lat_addr  = '0;
        lat_data  = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            cpu_we  = 1'b0;
            if (i == 0) begin
                lat_addr = mem_bus.mem_addr;
                lat_data = mem_bus.mem_wdata;
            end
            if (mem_bus.mem_write) wr_high++;
            if (cpu_wdone) begin
                wd_at = i;
                break;
            end
        end
    endtask

    int          rd_high, rv_at, err_at, wr_high, wd_at, txn0;
    logic [15:0] data, lat_addr, lat_data;

    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(negedge clk);

        chk("reset_ready",  {31'd0, cpu_ready},  32'd1);
        chk("reset_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("reset_wdone",  {31'd0, cpu_wdone},  32'd0);
        chk("reset_strobes", {30'd0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
        chk("reset_addr",   {16'd0, mem_bus.mem_addr},  32'd0);
        chk("reset_wdata",  {16'd0, mem_bus.mem_wdata}, 32'd0);
        chk("reset_rdata",  {16'd0, cpu_rdata},  32'd0);
        chk("reset_err",    {31'd0, err_timeout}, 32'd0);
        reset_n = 1'b1;

        // Miss read 0x0023.
        do_read(16'h0023, 40, rd_high, rv_at, err_at, data);
        chk("miss_rd_high", rd_high, 32'd7);
        chk("miss_rv_at",   rv_at,   32'd8);
        chk("miss_rdata",   {16'd0, data}, 32'h6000);
        @(negedge clk);
        chk("miss_rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);
        chk("miss_ready_back",   {31'd0, cpu_ready},  32'd1);

        // Hit read 0x0021, same line.
        do_read(16'h0021, 40, rd_high, rv_at, err_at, data);
        chk("hit_rd_high", rd_high, 32'd0);
        chk("hit_rv_at",   rv_at,   32'd0);
        chk("hit_rdata",   {16'd0, data}, 32'h0000);

        // Write-through 0x0022 <= BEEF, then read it back from the buffer.
        do_write(16'h0022, 16'hBEEF, 40, wr_high, wd_at, lat_addr, lat_data);
        chk("wr_high",     wr_high, 32'd7);
        chk("wr_wdone_at", wd_at,   32'd8);
        chk("wr_lat_addr", {16'd0, lat_addr}, 32'h0022);
        chk("wr_lat_data", {16'd0, lat_data}, 32'hBEEF);
        @(negedge clk);
        chk("wr_wdone_pulse", {31'd0, cpu_wdone}, 32'd0);
        do_read(16'h0022, 40, rd_high, rv_at, err_at, data);
        chk("wr_hit_rd_high", rd_high, 32'd0);
        chk("wr_hit_rdata",   {16'd0, data}, 32'hBEEF);

        // Timeout with memory silent.
        mem_block = 1'b1;
        do_read(16'h0100, 40, rd_high, rv_at, err_at, data);
        chk("to_rd_high", rd_high, 32'd31);
        chk("to_err_at",  err_at,  32'd31);
        chk("to_no_rvalid", rv_at, 32'hFFFF_FFFF);
        chk("to_ready",   {31'd0, cpu_ready}, 32'd1);
        mem_block = 1'b0;
        do_read(16'h0023, 40, rd_high, rv_at, err_at, data);
        chk("to_after_miss", rd_high, 32'd7);
        chk("to_after_rdata", {16'd0, data}, 32'h6000);
        chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset in the 3rd cycle of RD_WAIT, then a late done.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0040;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_read_on", {31'd0, mem_bus.mem_read}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_off", {31'd0, mem_bus.mem_read}, 32'd0);
        chk("rst_mid_ready",    {31'd0, cpu_ready},  32'd1);
        chk("rst_mid_err",      {31'd0, err_timeout}, 32'd0);
        chk("rst_mid_rdata",    {16'd0, cpu_rdata},   32'd0);
        reset_n  = 1'b1;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("late_done_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clk);
        chk("late_done_rvalid2", {31'd0, cpu_rvalid}, 32'd0);
        chk("late_done_ready",   {31'd0, cpu_ready},  32'd1);
        do_read(16'h0023, 40, rd_high, rv_at, err_at, data);
        chk("rst_buf_invalid", rd_high, 32'd7);
        chk("rst_rv_at",       rv_at,   32'd8);

        // Back-to-back misses on adjacent lines.
        overlap = 0;
        txn0    = rd_txn;
        do_read(16'h0024, 40, rd_high, rv_at, err_at, data);
        chk("b2b_a_rd_high", rd_high, 32'd7);
        chk("b2b_a_rdata",   {16'd0, data}, 32'hF01C);
        do_read(16'h0028, 40, rd_high, rv_at, err_at, data);
        chk("b2b_b_rd_high", rd_high, 32'd7);
        chk("b2b_b_rdata",   {16'd0, data}, 32'hF81C);
        chk("b2b_txns",      rd_txn - txn0, 32'd2);
        chk("b2b_no_overlap", overlap, 32'd0);

        // Top-of-range address.
        do_read(16'hFFFF, 40, rd_high, rv_at, err_at, data);
        chk("wrap_rd_high", rd_high, 32'd7);
        chk("wrap_rdata",   {16'd0, data}, 32'hAFFF);
        chk("wrap_addr",    {16'd0, mem_bus.mem_addr}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
